// File: rtl/costas_pkg.sv
// rtl/costas_pkg.sv - shared types and constants for the Costas-loop bit synchroniser
package costas_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_SPS    = 16;
  localparam int DEF_DW     = 15;
  localparam int DEF_LOOP_N = 8;
  localparam int DEF_LOCK_N = 32;

  // Five guard bits hold SPS+1 full-scale samples without wrapping
  function automatic int acc_width(input int dw);
    return dw + 5;
  endfunction

endpackage

// File: rtl/costas_iad.sv
// rtl/costas_iad.sv - integrate-and-dump over a variable-length symbol window
module costas_iad
  import costas_pkg::*;
#(
  parameter int SPS = DEF_SPS,
  parameter int DW  = DEF_DW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DW-1:0]           din,
  input  logic                           din_valid,
  input  logic [$clog2(SPS+2)-1:0]       win_len,
  output logic signed [acc_width(DW)-1:0] e_sum,
  output logic signed [acc_width(DW)-1:0] l_sum,
  output logic                           close
);

  localparam int AW = acc_width(DW);
  localparam int CW = $clog2(SPS + 2);
  localparam logic [CW-1:0] HALF = CW'(SPS / 2);

  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] e_acc, l_acc, din_x;
  logic                 early;

  assign din_x = {{(AW - DW){din[DW-1]}}, din};
  assign early = cnt < HALF;
  assign close = din_valid && (cnt == win_len - CW'(1));

  // Sums include the sample being accepted this cycle so the close decision sees the full window
  assign e_sum = (din_valid && early)  ? e_acc + din_x : e_acc;
  assign l_sum = (din_valid && !early) ? l_acc + din_x : l_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      e_acc <= '0;
      l_acc <= '0;
    end else if (din_valid) begin
      if (close) begin
        cnt   <= '0;
        e_acc <= '0;
        l_acc <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        e_acc <= e_sum;
        l_acc <= l_sum;
      end
    end
  end

endmodule

// File: rtl/costas_bit_sync.sv
// rtl/costas_bit_sync.sv - early/late bit synchroniser with window slipping and lock detection
module costas_bit_sync
  import costas_pkg::*;
#(
  parameter int SPS    = DEF_SPS,
  parameter int DW     = DEF_DW,
  parameter int LOOP_N = DEF_LOOP_N,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 locked,
  output logic                 slip_early,
  output logic                 slip_late
);

  localparam int AW = acc_width(DW);
  localparam int CW = $clog2(SPS + 2);
  localparam int EW = $clog2(LOOP_N + 1) + 1;
  localparam int RW = $clog2(LOCK_N + 1);

  localparam logic [CW-1:0]        LEN_NOM   = CW'(SPS);
  localparam logic [CW-1:0]        LEN_LONG  = CW'(SPS + 1);
  localparam logic [CW-1:0]        LEN_SHORT = CW'(SPS - 1);
  localparam logic signed [EW-1:0] ERR_MAX   = EW'(LOOP_N);
  localparam logic signed [EW-1:0] ERR_MIN   = EW'(-LOOP_N);
  localparam logic [RW-1:0]        RUN_LAST  = RW'(LOCK_N - 1);
  localparam logic signed [AW-1:0] ZERO      = '0;

  logic [CW-1:0]        win_len;
  logic signed [AW-1:0] e_sum, l_sum, p_sum;
  logic [AW-1:0]        mag_e, mag_l;
  logic                 close, go_late, go_early, slip;
  logic signed [EW-1:0] err_cnt, err_nxt;
  state_t               state_q, state_d;
  logic [RW-1:0]        run_q, run_d;
  logic                 slip_seen_q, slip_seen_d;

  costas_iad #(.SPS(SPS), .DW(DW)) u_iad (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .win_len   (win_len),
    .e_sum     (e_sum),
    .l_sum     (l_sum),
    .close     (close)
  );

  assign p_sum = e_sum + l_sum;
  assign mag_e = e_sum[AW-1] ? -e_sum : e_sum;
  assign mag_l = l_sum[AW-1] ? -l_sum : l_sum;

  // More energy late in the window means the window started early: push toward lengthening
  always_comb begin
    err_nxt = err_cnt;
    if (mag_l > mag_e)      err_nxt = err_cnt + EW'(1);
    else if (mag_l < mag_e) err_nxt = err_cnt - EW'(1);
  end

  assign go_late  = close && (err_nxt == ERR_MAX);
  assign go_early = close && (err_nxt == ERR_MIN);
  assign slip     = go_late || go_early;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt    <= '0;
      win_len    <= LEN_NOM;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      slip_early <= 1'b0;
      slip_late  <= 1'b0;
    end else begin
      dout_valid <= close;
      slip_late  <= go_late;
      slip_early <= go_early;
      if (close) begin
        dout    <= (p_sum >= ZERO);
        err_cnt <= slip ? '0 : err_nxt;
        win_len <= go_late ? LEN_LONG : (go_early ? LEN_SHORT : LEN_NOM);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEARCH;
      run_q       <= '0;
      slip_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      slip_seen_q <= slip_seen_d;
    end
  end

  // In LOCKED, run_q counts windows modulo LOCK_N; the period clear happens before the slip is counted
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    slip_seen_d = slip_seen_q;
    if (close) begin
      case (state_q)
        SEARCH: begin
          if (slip) begin
            run_d = '0;
          end else if (run_q == RUN_LAST) begin
            state_d     = LOCKED;
            run_d       = '0;
            slip_seen_d = 1'b0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        LOCKED: begin
          if (run_q == RUN_LAST) begin
            run_d       = '0;
            slip_seen_d = 1'b0;
          end else begin
            run_d = run_q + RW'(1);
          end
          if (slip) begin
            if (slip_seen_d) begin
              state_d     = SEARCH;
              run_d       = '0;
              slip_seen_d = 1'b0;
            end else begin
              slip_seen_d = 1'b1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
